// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO read and write controllers.
// Pure package: no latency or backpressure of its own.
package async_fifo_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int OCC_W       = 2;
  localparam int GW          = 32;

  function automatic logic [GW-1:0] bin2gray_f(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs convert correctly, so callers truncate the result.
  function automatic logic [GW-1:0] gray2bin_f(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b[GW-1] = g[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to gray pointer conversion.
// Combinational, no backpressure.
module bin2gray
  import async_fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] i_bin,
  output logic [W-1:0] o_gray
);

  assign o_gray = W'(bin2gray_f(GW'(i_bin)));

endmodule

// File: rtl/gray2bin.sv
// Gray to binary pointer conversion.
// Combinational, no backpressure.
module gray2bin
  import async_fifo_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  assign o_bin = W'(gray2bin_f(GW'(i_gray)));

endmodule

// File: rtl/rfwft_buf.sv
// Two-entry output/skid register for FWFT presentation, with occupancy count.
// Arrival to rdata takes 1 cycle; when rready is low it absorbs up to two words.
module rfwft_buf
  import async_fifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_inflight,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  input  logic              i_rready,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_pop,
  output logic [OCC_W-1:0]  o_occ
);

  logic              r_out_vld;
  logic              r_skid_vld;
  logic [DWIDTH-1:0] r_out_dat;
  logic [DWIDTH-1:0] r_skid_dat;
  logic              w_pop;

  assign w_pop    = r_out_vld & i_rready;
  assign o_pop    = w_pop;
  assign o_rvalid = r_out_vld;
  assign o_rdata  = r_out_dat;
  assign o_occ    = {1'b0, i_inflight} + {1'b0, r_out_vld} + {1'b0, r_skid_vld};

  always_ff @(posedge clk) begin
    if (srst) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_out_dat  <= '0;
      r_skid_dat <= '0;
    end else if (i_inflight) begin
      if (!r_out_vld || (w_pop && !r_skid_vld)) begin
        r_out_dat <= i_mem_rdata;
        r_out_vld <= 1'b1;
      end else if (w_pop) begin
        // Skid advances and the arriving word refills it; skid stays valid.
        r_out_dat  <= r_skid_dat;
        r_skid_dat <= i_mem_rdata;
      end else begin
        r_skid_dat <= i_mem_rdata;
        r_skid_vld <= 1'b1;
      end
    end else if (w_pop) begin
      if (r_skid_vld) begin
        r_out_dat  <= r_skid_dat;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rlogic_fwft.sv
// Read-side controller of the dual-clock FIFO: gray pointer sync, 1-cycle buffer read, FWFT output.
// Empty-to-rvalid takes 5 rclk edges; prefetches at most 2 words under stall. Optional rlevel via RLOGIC_RLEVEL_EN.
module rlogic_fwft
  import async_fifo_pkg::*;
#(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic              rclk,
  input  logic              srst,
  input  logic [AWIDTH:0]   wgray,
  output logic [AWIDTH:0]   rgray,
  output logic [AWIDTH-1:0] raddr,
  output logic              ren,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              rempty
`ifdef RLOGIC_RLEVEL_EN
  ,
  output logic [AWIDTH:0]   rlevel
`endif
);

  localparam int PW = AWIDTH + 1;

  logic [PW-1:0]    r_wsync [SYNC_STAGES];
  logic [PW-1:0]    r_rbin;
  logic             r_inflight;
  logic [PW-1:0]    w_wsync_bin;
  logic [PW-1:0]    w_rbin_next;
  logic [PW-1:0]    w_rgray_next;
  logic [OCC_W-1:0] w_occ;
  logic [OCC_W-1:0] w_need;
  logic             w_pop;

  always_ff @(posedge rclk) begin
    if (srst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_wsync[s] <= '0;
    end else begin
      r_wsync[0] <= wgray;
      for (int s = 1; s < SYNC_STAGES; s++) r_wsync[s] <= r_wsync[s-1];
    end
  end

  gray2bin #(.W(PW)) u_wsync_bin (
    .i_gray (r_wsync[SYNC_STAGES-1]),
    .o_bin  (w_wsync_bin)
  );

  // occ never falls below pop, so the subtraction cannot underflow.
  assign w_need      = w_occ - {{(OCC_W-1){1'b0}}, w_pop};
  assign ren         = !rempty && (w_need < OCC_W'(2));
  assign w_rbin_next = r_rbin + {{(PW-1){1'b0}}, ren};
  assign raddr       = r_rbin[AWIDTH-1:0];

  bin2gray #(.W(PW)) u_rgray_next (
    .i_bin  (w_rbin_next),
    .o_gray (w_rgray_next)
  );

  always_ff @(posedge rclk) begin
    if (srst) begin
      r_rbin     <= '0;
      rgray      <= '0;
      rempty     <= 1'b1;
      r_inflight <= 1'b0;
    end else begin
      r_rbin     <= w_rbin_next;
      rgray      <= w_rgray_next;
      rempty     <= (w_wsync_bin == w_rbin_next);
      r_inflight <= ren;
    end
  end

  rfwft_buf #(.DWIDTH(DWIDTH)) u_buf (
    .clk         (rclk),
    .srst        (srst),
    .i_inflight  (r_inflight),
    .i_mem_rdata (mem_rdata),
    .i_rready    (rready),
    .o_rdata     (rdata),
    .o_rvalid    (rvalid),
    .o_pop       (w_pop),
    .o_occ       (w_occ)
  );

`ifdef RLOGIC_RLEVEL_EN
  always_ff @(posedge rclk) begin
    if (srst) rlevel <= '0;
    else      rlevel <= (w_wsync_bin - r_rbin) + PW'(w_occ);
  end
`endif

endmodule

// File: tb/tb_rlogic_fwft.sv
// Randomized self-checking bench for rlogic_fwft against a queue-based FIFO model.
// Covers reset, first-word latency, burst, stall, pointer wrap and mid-run reset.
module tb_rlogic_fwft;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          rclk = 1'b0;
  logic          srst;
  logic [PW-1:0] wgray;
  logic [PW-1:0] rgray;
  logic [AW-1:0] raddr;
  logic          ren;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;
  logic          rempty;
`ifdef RLOGIC_RLEVEL_EN
  logic [PW-1:0] rlevel;
`endif

  always #5 rclk = ~rclk;

  rlogic_fwft #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .rclk      (rclk),
    .srst      (srst),
    .wgray     (wgray),
    .rgray     (rgray),
    .raddr     (raddr),
    .ren       (ren),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .rempty    (rempty)
`ifdef RLOGIC_RLEVEL_EN
    ,
    .rlevel    (rlevel)
`endif
  );

  // Buffer RAM model with a 1-cycle synchronous read port.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge rclk) if (ren) mem_rdata <= mem[raddr];

  int            n_chk, n_fail;
  int            n_wr, n_fetch, n_pop, cyc;
  logic [DW-1:0] expq [$];
  bit            prev_hold;
  logic [DW-1:0] prev_dat;
  logic          drv_rready;

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] b;
    b = v[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[n_wr % DEPTH] = d;
    n_wr++;
    wgray = gray(n_wr);
    expq.push_back(d);
  endtask

  // Called after inputs are settled for the upcoming edge.
  task automatic monitor();
    logic pop, ovf;
    cyc++;
    check("rgray", 32'(rgray), 32'(gray(n_fetch)));
    check("raddr", 32'(raddr), 32'(n_fetch % DEPTH));
    if (ren) begin
      check("ren_avail", 32'(n_fetch < n_wr), 32'd1);
      n_fetch++;
    end
    pop = rvalid && rready;
    if (prev_hold) begin
      check("hold_vld", 32'(rvalid), 32'd1);
      check("hold_dat", 32'(rdata), 32'(prev_dat));
    end
    if (pop) begin
      check("pop_q_empty", 32'(expq.size() == 0), 32'd0);
      if (expq.size() > 0) check("rdata", 32'(rdata), 32'(expq.pop_front()));
      n_pop++;
    end
    check("prefetch", 32'((n_fetch - n_pop) <= 2), 32'd1);
    ovf = dut.r_inflight && dut.u_buf.r_out_vld && dut.u_buf.r_skid_vld && !pop;
    check("overflow", 32'(ovf), 32'd0);
    prev_hold = rvalid && !rready;
    prev_dat  = rdata;
  endtask

  task automatic step();
    @(negedge rclk);
    rready = drv_rready;
    #1;
    monitor();
  endtask

  // Writer and reader are reset together; model state is cleared with them.
  task automatic do_reset(input int ncyc);
    srst      = 1'b1;
    rready    = 1'b0;
    wgray     = '0;
    n_wr      = 0;
    n_fetch   = 0;
    n_pop     = 0;
    prev_hold = 1'b0;
    expq.delete();
    repeat (ncyc) @(negedge rclk);
    srst   = 1'b0;
    rready = drv_rready;
    #1;
    monitor();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rempty"}, 32'(rempty), 32'd1);
    check({tag, "_ren"},    32'(ren),    32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_rgray"},  32'(rgray),  32'd0);
    check({tag, "_raddr"},  32'(raddr),  32'd0);
    check({tag, "_rdata"},  32'(rdata),  32'd0);
`ifdef RLOGIC_RLEVEL_EN
    check({tag, "_rlevel"}, 32'(rlevel), 32'd0);
`endif
  endtask

  initial begin
    int first, last;
    bit reached;
    n_chk = 0; n_fail = 0; cyc = 0;
    srst = 1'b1; wgray = '0; rready = 1'b0; drv_rready = 1'b0;

    // Reset then idle
    do_reset(2);
    check_reset("rst");
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_rempty", 32'(rempty), 32'd1);
      check("idle_ren",    32'(ren),    32'd0);
      check("idle_rvalid", 32'(rvalid), 32'd0);
      check("idle_rgray",  32'(rgray),  32'd0);
    end

    // Single word latency: wgray changes before edge 1
    drv_rready = 1'b1;
    do_reset(2);
    write_word(8'hA5);
    step(); step();
    check("lat_e2_rempty", 32'(rempty), 32'd1);
    step();
    check("lat_e3_rempty", 32'(rempty), 32'd0);
    check("lat_e3_ren",    32'(ren),    32'd1);
    check("lat_e3_raddr",  32'(raddr),  32'd0);
    step();
    check("lat_e4_rvalid", 32'(rvalid), 32'd0);
    check("lat_e4_ren",    32'(ren),    32'd0);
    check("lat_e4_rempty", 32'(rempty), 32'd1);
    check("lat_e4_rgray",  32'(rgray),  32'h01);
    step();
    check("lat_e5_rvalid", 32'(rvalid), 32'd1);
    check("lat_e5_rdata",  32'(rdata),  32'hA5);
    step();
    check("lat_e6_rvalid", 32'(rvalid), 32'd0);

    // Full-depth burst with rready held high
    do_reset(2);
    for (int i = 0; i < 16; i++) write_word(8'(i));
    first = -1; last = -1;
    for (int i = 0; i < 60 && last < 0; i++) begin
      step();
      if (n_pop == 1 && first < 0) first = cyc;
      if (n_pop == 16) last = cyc;
    end
    check("burst_pops",   32'(n_pop), 32'd16);
    check("burst_bubble", 32'(last - first), 32'd15);
    check("burst_rgray",  32'(rgray), 32'h18);
    check("burst_raddr",  32'(raddr), 32'd0);

    // Stall: only two words are prefetched
    drv_rready = 1'b0;
    do_reset(2);
    for (int i = 0; i < 10; i++) write_word(8'(8'h30 + i));
    repeat (20) step();
    check("stall_fetches", 32'(n_fetch), 32'd2);
    check("stall_ren",     32'(ren),     32'd0);
    check("stall_rvalid",  32'(rvalid),  32'd1);
    check("stall_rdata",   32'(rdata),   32'h30);
`ifdef RLOGIC_RLEVEL_EN
    check("stall_rlevel",  32'(rlevel),  32'd10);
`endif
    drv_rready = 1'b1;
    for (int i = 0; i < 60 && n_pop < 10; i++) step();
    check("stall_drain", 32'(n_pop), 32'd10);

    // Pointer wrap with random writer gaps and random consumer stalls
    do_reset(2);
    for (int i = 0; i < 2000 && n_pop < 40; i++) begin
      drv_rready = ($urandom_range(0, 3) != 0);
      step();
      if (n_wr < 40 && (n_wr - n_pop) < DEPTH && $urandom_range(0, 1) == 1)
        write_word(8'($urandom));
    end
    check("wrap_pops",  32'(n_pop), 32'd40);
    check("wrap_rgray", 32'(rgray), 32'h0C);

    // Reset while words are buffered and a read is in flight
    drv_rready = 1'b1;
    do_reset(2);
    for (int i = 0; i < 10; i++) write_word(8'(8'h50 + i));
    reached = 1'b0;
    for (int i = 0; i < 30 && !reached; i++) begin
      step();
      if (rvalid && dut.r_inflight) reached = 1'b1;
    end
    check("mid_reached", 32'(reached), 32'd1);
    do_reset(1);
    check_reset("mid_rst");
    for (int i = 0; i < 3; i++) write_word(8'(8'hC0 + i));
    for (int i = 0; i < 30 && n_pop < 3; i++) step();
    check("post_rst_pops", 32'(n_pop), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rlogic_fwft.md
Name: rlogic_fwft

Overview:
- Read-side controller of the dual-clock FIFO; the counterpart of the write-side controller.
- Synchronizes the writer's gray pointer into rclk and keeps the binary and gray read pointers.
- Drives a synchronous-read buffer port (1-cycle read latency).
- Presents data to the consumer as first-word-fall-through with a valid/ready handshake, at full throughput of one word per cycle.

Parameters:
- AWIDTH, 4, buffer address width; depth = 2**AWIDTH; pointers are AWIDTH+1 bits, MSB is the wrap bit.
- DWIDTH, 8, data width.

Ports:
- rclk  in  1  reader clock.
- srst  in  1  synchronous active-high reset.
- wgray  in  AWIDTH+1  gray write pointer from the writer domain.
- rgray  out  AWIDTH+1  gray read pointer to the writer domain; registered.
- raddr  out  AWIDTH  buffer read address = rbin[AWIDTH-1:0].
- ren  out  1  buffer read enable; mem_rdata is valid the cycle after ren.
- mem_rdata  in  DWIDTH  buffer read data.
- rdata  out  DWIDTH  consumer data.
- rvalid  out  1  rdata is valid.
- rready  in  1  consumer accepts; a pop occurs when rvalid && rready.
- rempty  out  1  buffer holds no unfetched words (this is not a consumer-side empty flag).

Behaviour:
- Clocking and reset: single clock rclk; srst is synchronous, active-high.
- Reset values: all state 0 except rempty=1. Outputs rgray=0, raddr=0, ren=0, rvalid=0, rdata=0.
- Synchronizer: wgray -> FF -> FF -> wsync, then gray-to-binary -> wsync_bin.
- Counters:
  - rbin_next = rbin + ren, wrapping mod 2**(AWIDTH+1).
  - rbin <= rbin_next.
  - rgray <= bin2gray(rbin_next), so rgray is glitch-free from a register.
- Empty flag: rempty <= (wsync_bin == rbin_next).
- Occupancy: occ = inflight + rvalid + skid_valid, range 0..2. inflight <= ren.
- Fetch rule: ren = !rempty && (occ - pop) < 2.
- Data steering (order preserved), on arrival (inflight=1):
  - Output reg empty, or popped this cycle with skid empty: mem_rdata loads the output reg.
  - Otherwise: mem_rdata loads the skid reg.
  - On a pop with skid_valid=1: skid moves to the output reg; any simultaneous arrival loads the skid.
- Overflow guard: arrival into a full output+skid cannot occur by construction. The bench asserts this.
- Latency, empty FIFO, counting rclk edges after wgray changes:
  - Edge 3: rempty falls.
  - Edge 4: ren is sampled and the buffer read occurs.
  - Edge 5: rvalid rises.
- Throughput: with rready held 1 and rempty=0, one pop per cycle sustained.
- Wrap-around: at rbin=2**(AWIDTH+1)-1, the next increment goes to 0. raddr wraps at depth.
- Stall behaviour: while rready=0, at most 2 words are prefetched, then ren=0. rdata stays stable while rvalid && !rready.
- Drain: when the last word is fetched, rempty rises the same edge the counter advances. rvalid stays 1 until the remaining words are popped.
- srst mid-operation:
  - Inflight and buffered words are discarded; the next cycle shows reset values.
  - Writer-side reset must be applied concurrently (system requirement).

Optional Feature:
- Macro RLOGIC_RLEVEL_EN.
- Defined: adds output rlevel [AWIDTH:0], registered, equal to (wsync_bin - rbin) + occ. This is words available to the consumer, lagging by the sync delay plus 1 cycle. Reset 0.
- Undefined: the port and logic are absent; no other behaviour changes.

Decomposition:
- Shared package async_fifo_pkg holds:
  - SYNC_STAGES=2.
  - OCC_W=2.
  - Helper functions bin2gray_f/gray2bin_f, used by both controllers.
- Reuse the existing bin2gray and gray2bin modules for pointer conversion.
- One natural sub-module: rfwft_buf, the 2-entry output/skid register with occ accounting, taking inflight/mem_rdata/rready.

Test Plan:
- Reset then idle, wgray=0: rempty=1, ren=0, rvalid=0, rgray=0 for 20 cycles.
- wgray 0->1 (word 0xA5 at addr 0), rready=1: ren at edge 4 with raddr=0; rvalid=1, rdata=0xA5 at edge 5; rempty=1 afterward; rgray=00001.
- Writer fills 16 words (wgray for 16 = 11000), rready=1: 16 consecutive pops, no bubbles after the first; data order 0..15; final rbin=16, raddr=0.
- rready=0 with 10 words available: exactly 2 ren pulses, then ren=0. rdata holds word 0. Releasing rready yields words 0..9 in order.
- Pointer wrap: run 40 words through: rbin passes 31->0, rgray matches gray(rbin) every cycle, no data loss.
- srst asserted with rvalid=1, skid full, inflight=1: next cycle shows reset values. With RLOGIC_RLEVEL_EN defined, rlevel=0.
